// File: rtl/nanorisc_pkg.sv
// Shared nanoRISC definitions: opcode encodings, default widths and fetch FSM states.
package nanorisc_pkg;

  localparam logic [2:0] OP_SUM  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_LWI  = 3'b011;
  localparam logic [2:0] OP_SWI  = 3'b100;
  localparam logic [2:0] OP_BNE  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;
  localparam logic [2:0] OP_SEND = 3'b111;

  localparam int unsigned ADDR_W_DEFAULT  = 8;
  localparam int unsigned INSTR_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    StFetch,
    StWait,
    StExec,
    StHalt
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC computation: pc+1, plus the sign-extended 8-bit offset when a bne is taken.
// All arithmetic wraps modulo 2^ADDR_W.
module fetch_pc_next #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [7:0]        offset_i,
  input  logic              is_branch_i,
  input  logic              alu_zero_i,
  output logic [ADDR_W-1:0] pc_next_o
);

  logic [ADDR_W-1:0] offset_ext;

  // bne is taken when the operands differ, i.e. the ALU zero flag is clear
  always_comb begin
    offset_ext = '0;
    if (is_branch_i && !alu_zero_i) begin
      offset_ext = ADDR_W'($signed(offset_i));
    end
    pc_next_o = pc_i + ADDR_W'(1) + offset_ext;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: FETCH -> WAIT -> EXEC per instruction, HALT when PCWrite drops.
// Optional WAIT watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
  import nanorisc_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEFAULT,
  parameter int unsigned INSTR_W        = INSTR_W_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               PCWrite,
  input  logic               isBranch,
  input  logic               alu_zero,
  output logic [INSTR_W-1:0] instr,
  output logic [2:0]         opcode,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic               fetch_err
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d, pc_next;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               req_q, req_d;
  logic               ivld_q, ivld_d;
  logic               halt_q, halt_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  fetch_pc_next #(
    .ADDR_W (ADDR_W)
  ) u_pc_next (
    .pc_i        (pc_q),
    .offset_i    (ir_q[7:0]),
    .is_branch_i (isBranch),
    .alu_zero_i  (alu_zero),
    .pc_next_o   (pc_next)
  );

  // Next-state and registered-output logic; outputs are computed for the state being entered
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    req_d   = 1'b0;
    ivld_d  = 1'b0;
    halt_d  = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      StFetch: begin
        // req_q is low only in the FETCH cycle held by reset; the first edge raises the request
        if (req_q) begin
          state_d = StWait;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          req_d = 1'b1;
        end
      end
      StWait: begin
        // A response on the limit cycle takes priority over the watchdog
        if (imem_valid) begin
          ir_d    = imem_rdata;
          state_d = StExec;
          ivld_d  = 1'b1;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (32'(cnt_q) + 32'd1 == TIMEOUT_CYCLES) begin
          err_d   = 1'b1;
          state_d = StHalt;
          halt_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StExec: begin
        if (PCWrite) begin
          pc_d    = pc_next;
          state_d = StFetch;
          req_d   = 1'b1;
        end else begin
          state_d = StHalt;
          halt_d  = 1'b1;
        end
      end
      StHalt: begin
        halt_d = 1'b1;
      end
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  // FSM state, PC, IR and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      pc_q    <= '0;
      ir_q    <= '0;
      req_q   <= 1'b0;
      ivld_q  <= 1'b0;
      halt_q  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      req_q   <= req_d;
      ivld_q  <= ivld_d;
      halt_q  <= halt_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = ir_q;
  assign opcode      = ir_q[INSTR_W-1 -: 3];
  assign instr_valid = ivld_q;
  assign halted      = halt_q;

`ifdef FETCH_TIMEOUT_EN
  assign fetch_err = err_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign fetch_err      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a transaction-level PC/IR model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fetch_unit;

  localparam int TO = 15;

  logic        clock, reset;
  logic        imem_req, imem_valid;
  logic [7:0]  imem_addr, pc;
  logic [15:0] imem_rdata, instr;
  logic        PCWrite, isBranch, alu_zero;
  logic [2:0]  opcode;
  logic        instr_valid, halted, fetch_err;

  int total = 0;
  int bad   = 0;

  // Model state: what the architecture must show, updated per completed transaction
  logic [7:0]  m_pc;
  logic [15:0] m_ir;
  logic        m_halted, m_err;

  fetch_unit #(
    .ADDR_W         (8),
    .INSTR_W        (16),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .PCWrite     (PCWrite),
    .isBranch    (isBranch),
    .alu_zero    (alu_zero),
    .instr       (instr),
    .opcode      (opcode),
    .instr_valid (instr_valid),
    .pc          (pc),
    .halted      (halted),
    .fetch_err   (fetch_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    chk("pc", pc, m_pc);
    chk("imem_addr", imem_addr, m_pc);
    chk("instr", instr, m_ir);
    chk("opcode", opcode, m_ir[15:13]);
    chk("halted", halted, m_halted);
    chk("fetch_err", fetch_err, m_err);
    if (m_halted) begin
      chk("halt_req", imem_req, 0);
      chk("halt_vld", instr_valid, 0);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    imem_valid = 1'b0;
    m_pc = '0; m_ir = '0; m_halted = 1'b0; m_err = 1'b0;
    repeat (cycles) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Wait (bounded) for a request and check how many cycles it took and its address
  task automatic wait_req(input int exp_gap);
    int n = 0;
    while (!imem_req && n < 40) begin
      tick();
      n++;
    end
    chk("req_gap", n, exp_gap);
    chk("req_addr", imem_addr, m_pc);
  endtask

  // Called in the first WAIT cycle: hold valid low 'extra' cycles, then return the word
  task automatic respond(input logic [15:0] ir, input logic pcw, input logic br,
                         input logic z, input int extra);
    int off;
    repeat (extra) begin
      chk("wait_no_vld", instr_valid, 0);
      tick();
    end
    imem_valid = 1'b1; imem_rdata = ir;
    PCWrite = pcw; isBranch = br; alu_zero = z;
    tick();
    imem_valid = 1'b0;
    m_ir = ir;
    chk("exec_vld", instr_valid, 1);
    tick();
    chk("exec_one_cycle", instr_valid, 0);
    if (pcw) begin
      off  = (br && !z) ? int'($signed(ir[7:0])) : 0;
      m_pc = 8'((int'(m_pc) + 1 + off) & 255);
    end else begin
      m_halted = 1'b1;
    end
  endtask

  task automatic run_instr(input logic [15:0] ir, input logic pcw, input logic br,
                           input logic z, input int extra, input int exp_gap);
    wait_req(exp_gap);
    tick();
    chk("wait_no_req", imem_req, 0);
    respond(ir, pcw, br, z, extra);
  endtask

  initial begin
    reset = 1'b1; imem_valid = 1'b0; imem_rdata = '0;
    PCWrite = 1'b0; isBranch = 1'b0; alu_zero = 1'b0;
    m_pc = '0; m_ir = '0; m_halted = 1'b0; m_err = 1'b0;
    tick();
    do_reset(2);

    // Reset values
    chk("rst_pc", pc, 0);
    chk("rst_instr", instr, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_vld", instr_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", fetch_err, 0);

    // First edge after reset issues the request to address 0
    tick();
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 0);

    // Sequential fetches, 3 cycles each
    run_instr(16'h0001, 1'b1, 1'b0, 1'b0, 0, 0);
    run_instr(16'h2002, 1'b1, 1'b0, 1'b0, 0, 0);
    run_instr(16'h4003, 1'b1, 1'b0, 1'b0, 0, 0);
    run_instr(16'h6004, 1'b1, 1'b0, 1'b0, 0, 0);
    chk("seq_pc4", pc, 4);
    // Slow memory, and a bne with alu_zero=1 which falls through
    run_instr(16'hA0FE, 1'b1, 1'b1, 1'b1, 2, 0);
    chk("slow_pc5", pc, 5);

    // bne at pc=5 with offset -2: taken -> 4, not taken -> 6
    run_instr(16'hA0FE, 1'b1, 1'b1, 1'b0, 0, 0);
    chk("bne_taken", pc, 4);
    run_instr(16'h0000, 1'b1, 1'b0, 1'b0, 0, 0);
    run_instr(16'hA0FE, 1'b1, 1'b1, 1'b1, 0, 0);
    chk("bne_not_taken", pc, 6);

    // Wraparound: 6 -> 200, 200 +1+127 -> 72, 72 -> 255, 255 -> 0
    run_instr(16'hA0C1, 1'b1, 1'b1, 1'b0, 0, 0);
    chk("neg_branch", pc, 200);
    run_instr(16'hA07F, 1'b1, 1'b1, 1'b0, 0, 0);
    chk("wrap_branch", pc, 72);
    run_instr(16'hA0B6, 1'b1, 1'b1, 1'b0, 0, 0);
    chk("to_255", pc, 255);
    run_instr(16'h2000, 1'b1, 1'b0, 1'b0, 1, 0);
    chk("wrap_seq", pc, 0);

    // Reset in the middle of WAIT at pc=9, then a stale response
    run_instr(16'hA008, 1'b1, 1'b1, 1'b0, 0, 0);
    chk("pc9", pc, 9);
    wait_req(0);
    tick();
    tick();
    reset = 1'b1;
    m_pc = '0; m_ir = '0; m_halted = 1'b0; m_err = 1'b0;
    #1;
    chk("async_rst_pc", pc, 0);
    chk("async_rst_req", imem_req, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    imem_valid = 1'b1; imem_rdata = 16'h1234;
    chk("post_rst_req", imem_req, 1);
    chk("post_rst_addr", imem_addr, 0);
    tick();
    imem_valid = 1'b0;
    chk("stale_ignored", instr, 0);
    respond(16'h0000, 1'b1, 1'b0, 1'b0, 0);
    chk("after_stale_pc", pc, 1);

`ifndef FETCH_TIMEOUT_EN
    // Without the watchdog a long wait is simply tolerated
    run_instr(16'h0000, 1'b1, 1'b0, 1'b0, 20, 0);
    chk("long_wait_pc", pc, 2);
    chk("long_wait_err", fetch_err, 0);
`endif

    // HALT: stays put, no requests, stray responses ignored
    run_instr(16'hC000, 1'b0, 1'b0, 1'b0, 0, 0);
    chk("halt_flag", halted, 1);
    for (int i = 0; i < 4; i++) begin
      imem_valid = 1'b1; imem_rdata = 16'hFFFF; PCWrite = 1'b1;
      tick();
      chk("halt_stray_req", imem_req, 0);
      chk("halt_stray_ir", instr, 16'hC000);
    end
    imem_valid = 1'b0;

`ifdef FETCH_TIMEOUT_EN
    // Watchdog fires exactly TO cycles after entering WAIT
    do_reset(2);
    wait_req(1);
    tick();
    repeat (TO - 1) tick();
    chk("to_not_yet", halted, 0);
    tick();
    m_halted = 1'b1; m_err = 1'b1;
    chk("to_halted", halted, 1);
    chk("to_err", fetch_err, 1);
    // Response on the limit cycle wins
    do_reset(2);
    run_instr(16'h0000, 1'b1, 1'b0, 1'b0, TO - 1, 1);
    chk("to_edge_err", fetch_err, 0);
    chk("to_edge_pc", pc, 1);
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 8, meaning PC and instruction-memory address width in bits.
REQ-002 Parameter INSTR_W, default 16, meaning instruction width; opcode is bits [INSTR_W-1:INSTR_W-3].
REQ-003 Parameter TIMEOUT_CYCLES, default 15, meaning watchdog limit in cycles; used only when FETCH_TIMEOUT_EN is defined.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 imem_req  out  1  fetch request, one-cycle pulse.
REQ-008 imem_addr  out  ADDR_W  fetch address; equals pc.
REQ-009 imem_valid  in  1  read data valid; accepted only in WAIT.
REQ-010 imem_rdata  in  INSTR_W  instruction word, sampled when imem_valid=1 in WAIT.
REQ-011 PCWrite  in  1  from control unit; 0 means halt.
REQ-012 isBranch  in  1  from control unit; instruction is bne.
REQ-013 alu_zero  in  1  ALU zero flag for the current instruction.
REQ-014 instr  out  INSTR_W  instruction register (IR).
REQ-015 opcode  out  3  IR[INSTR_W-1:INSTR_W-3]; feeds the control unit.
REQ-016 instr_valid  out  1  high only in EXEC; downstream commits register and memory writes only then.
REQ-017 pc  out  ADDR_W  current program counter.
REQ-018 halted  out  1  high in HALT.
REQ-019 fetch_err  out  1  sticky watchdog error flag.

Function
REQ-020 The FSM SHALL have states FETCH, WAIT, EXEC and HALT.
REQ-021 FETCH: imem_req=1 for exactly that cycle, with imem_addr=pc; next state is WAIT.
REQ-022 WAIT: imem_req=0; on imem_valid=1, IR<=imem_rdata and next state is EXEC; otherwise the FSM stays in WAIT.
REQ-023 EXEC lasts one cycle with instr_valid=1, and PCWrite, isBranch and alu_zero are sampled at its end.
REQ-024 At the end of EXEC with PCWrite=0: pc is unchanged and next state is HALT.
REQ-025 At the end of EXEC with PCWrite=1: pc<=pc_next and next state is FETCH.
REQ-026 pc_next = pc+1+sext(IR[7:0]) when isBranch=1 and alu_zero=0 (bne taken); otherwise pc_next = pc+1.
REQ-027 pc_next arithmetic SHALL be modulo 2^ADDR_W, so pc wraps 255->0 and a negative offset below 0 wraps.
REQ-028 Minimum latency is 3 cycles per instruction; each extra cycle imem_valid stays low adds 1.
REQ-029 imem_valid in FETCH, EXEC or HALT SHALL be ignored, and IR SHALL be unchanged.
REQ-030 HALT is absorbing: all inputs ignored, imem_req=0, instr_valid=0; only reset exits it.
REQ-031 instr and opcode SHALL hold the last IR value in every state.

Reset
REQ-032 Reset asserted in any state SHALL immediately force: state=FETCH, pc=0, IR=0, imem_req=0, instr_valid=0, halted=0, fetch_err=0, watchdog counter=0.
REQ-033 After reset deasserts, the first rising edge SHALL issue imem_req with imem_addr=0.
REQ-034 A memory response pending from before reset SHALL be discarded, because the FSM is not in WAIT when it arrives.

Configuration
REQ-035 Macro FETCH_TIMEOUT_EN defined: a counter increments each WAIT cycle and clears on entering WAIT.
REQ-036 With FETCH_TIMEOUT_EN defined, if the counter reaches TIMEOUT_CYCLES without imem_valid, fetch_err<=1, the FSM goes to HALT and halted=1.
REQ-037 With FETCH_TIMEOUT_EN defined, imem_valid arriving in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win: the FSM goes to EXEC and no error is flagged.
REQ-038 Macro FETCH_TIMEOUT_EN undefined: no counter exists, WAIT waits indefinitely, and fetch_err is tied to 0.

Structure
REQ-039 Shared package nanorisc_pkg SHALL hold: opcode constants OP_SUM=000, OP_SUB=001, OP_MUL=010, OP_LWI=011, OP_SWI=100, OP_BNE=101, OP_HALT=110, OP_SEND=111; the default ADDR_W and INSTR_W values; and the fetch_state_t typedef.
REQ-040 One combinational sub-module, fetch_pc_next, SHALL compute pc_next from pc, IR[7:0], isBranch and alu_zero.

Verification
REQ-041 Reset, then memory returns valid 1 cycle after each request with PCWrite=1 and isBranch=0 -> imem_addr sequence 0,1,2,3; instr_valid pulses every 3rd cycle.
REQ-042 IR=16'hA0FE at pc=5 with isBranch=1: alu_zero=0 -> next pc=4; alu_zero=1 -> next pc=6.
REQ-043 pc=255 with a non-branch instruction -> next pc=0; IR[7:0]=8'h7F at pc=200 with bne taken -> next pc=72 (wrap).
REQ-044 Instruction 16'hC000 with PCWrite=0 -> halted=1, pc held, no further imem_req, and stray imem_valid pulses ignored.
REQ-045 Reset asserted mid-WAIT at pc=9, then a stale imem_valid one cycle after reset deasserts -> IR stays 0 and the next request is to address 0.
REQ-046 FETCH_TIMEOUT_EN defined and imem_valid held low -> fetch_err=1 and halted=1 exactly TIMEOUT_CYCLES cycles after entering WAIT; valid on the limit cycle -> EXEC and no error.
